piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out stage directly upstream of the serial sequence detector. Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on dout, which drives the detector's din input. Back-to-back words stream with no idle gap, so sequences that span a word boundary remain detectable. Between frames, dout idles high.

Parameters:
WIDTH, 8, data bits per word; legal range 2..32
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  WIDTH  parallel word to serialise
load_valid  input  1  data_in is valid this cycle
load_ready  output  1  block accepts a word this cycle; transfer occurs when load_valid and load_ready are both 1 on a rising edge
dout  output  1  serial bit stream; feeds the detector's din
dout_valid  output  1  dout carries a data (or parity) bit this cycle
frame_start  output  1  high during the first bit of each word
busy  output  1  high in the SHIFT state

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release): state=IDLE, shift register=0, bit count=0, dout=1, dout_valid=0, frame_start=0, busy=0.
- load_ready is combinational:
  - 1 in IDLE.
  - 1 in SHIFT only during the final bit of the frame.
  - 0 otherwise.
  - Forced to 0 while reset is low.
- States:
  - IDLE: on accept -> SHIFT.
  - SHIFT: on the final bit, if accept -> stay in SHIFT and reload; else -> IDLE.
- Latency: first bit appears on dout in the cycle after the accepting edge. dout_valid=1 and frame_start=1 in that cycle.
- Frame length: FRAME = WIDTH (or WIDTH+1 with parity). Bits occupy exactly FRAME consecutive cycles.
- Outputs are registered. dout comes from the shift register end selected by MSB_FIRST; the register shifts by one position each SHIFT cycle.
- Bit counter:
  - Width $clog2(WIDTH+2).
  - Loaded to FRAME-1 on accept, decremented each SHIFT cycle.
  - Value 0 marks the final bit.
- Back-to-back: an accept on the final bit reloads the register and counter. The next word's first bit follows with zero gap, and frame_start pulses again.
- load_valid while load_ready=0 is ignored. data_in is not sampled, and the upstream source must hold its word.
- Idle: dout=1 and dout_valid=0. The detector therefore sees 1s and stays in its initial state.
- Reset mid-frame: the frame is aborted immediately, the remaining bits are discarded, and the outputs take their reset values. No partial resume.
- data_in changes while not accepted have no effect.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined: after the last data bit, one even-parity bit (XOR of all WIDTH data bits, captured at accept) is sent with dout_valid=1. FRAME=WIDTH+1, and load_ready rises during the parity-bit cycle.
- Undefined: no parity logic, and FRAME=WIDTH.

Decomposition:
- Package piso_pkg:
  - state enum (IDLE=1'b0, SHIFT=1'b1)
  - localparam IDLE_LEVEL=1'b1
  - function computing the counter width from WIDTH
- One natural sub-module: piso_bit_counter. It is a loadable down-counter with load, enable and a zero flag, instantiated once.
- The shift register and FSM stay in the top module.

Test Plan:
1. Reset release, then load 0x5A with WIDTH=8, MSB_FIRST=1 -> load_ready=1 at accept; dout over the next 8 cycles = 0,1,0,1,1,0,1,0; dout_valid high for exactly 8 cycles; frame_start only in cycle 1; then dout=1, dout_valid=0.
2. Back-to-back 0xA5 then 0x3C, with load_valid held for the second word -> second accept coincides with bit 8 of the first; 16 contiguous valid bits 10100101 00111100; frame_start in cycles 1 and 9.
3. load_valid pulsed during bit 3 of a frame -> load_ready=0 and no accept; the word is taken only on the final bit while valid is still held.
4. Assert reset after 3 bits of 0xFF -> dout=1, dout_valid=0, busy=0 within the same cycle (asynchronous); after release, load_ready=1 and no residual bits are emitted.
5. MSB_FIRST=0, load 0x01 -> dout sequence 1,0,0,0,0,0,0,0.
6. PISO_PARITY_EN defined: load 0x07 -> 9 valid bits 0,0,0,0,0,1,1,1,1 (parity=1); load 0x03 -> parity bit 0; load_ready high in the 9th cycle.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
// Parity framing is enabled by defining PISO_PARITY_EN.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Line level driven on dout between frames so the detector sees a run of 1s.
    localparam logic IDLE_LEVEL = 1'b1;

    // The counter must hold FRAME-1, which is at most WIDTH when parity is on.
    function automatic int piso_cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter marking the remaining bits of a serial frame.
// Saturates at zero so an idle serializer keeps a stable zero flag.
module piso_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [CW-1:0] i_load_value,
    output logic          o_zero
);

    logic [CW-1:0] r_count;
    logic          w_zero;

    assign w_zero = (r_count == '0);
    assign o_zero = w_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && !w_zero) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage feeding the sequence detector's din input.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = piso_cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    piso_state_e      r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_dout;
    logic             r_dout_valid;
    logic             r_frame_start;

    logic             w_zero;
    logic             w_final;
    logic             w_accept;
    logic             w_fill;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_load_shift;
    logic [WIDTH-1:0] w_next_shift;

    // The parity bit rides in the slot vacated by the first data bit, so it
    // falls out of the register right after the last data bit.
`ifdef PISO_PARITY_EN
    assign w_fill = ^data_in;
`else
    assign w_fill = 1'b0;
`endif

    assign w_final    = (r_state == SHIFT) && w_zero;
    assign load_ready = reset && ((r_state == IDLE) || w_final);
    assign w_accept   = load_valid && load_ready;

    assign w_first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    assign w_load_shift = MSB_FIRST ? {data_in[WIDTH-2:0], w_fill}
                                    : {w_fill, data_in[WIDTH-1:1]};
    assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_next_shift = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shift[WIDTH-1:1]};

    piso_bit_counter #(
        .CW (CW)
    ) u_bit_counter (
        .clk          (clk),
        .rst_n        (reset),
        .i_load       (w_accept),
        .i_en         (r_state == SHIFT),
        .i_load_value (LAST_IDX),
        .o_zero       (w_zero)
    );

    // An accept on the final bit takes priority, giving gap-free back-to-back frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_dout        <= IDLE_LEVEL;
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_accept;
            if (w_accept) begin
                r_state      <= SHIFT;
                r_shift      <= w_load_shift;
                r_dout       <= w_first_bit;
                r_dout_valid <= 1'b1;
            end else if (r_state == SHIFT) begin
                if (w_zero) begin
                    r_state      <= IDLE;
                    r_dout       <= IDLE_LEVEL;
                    r_dout_valid <= 1'b0;
                end else begin
                    r_shift <= w_next_shift;
                    r_dout  <= w_next_bit;
                end
            end
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign frame_start = r_frame_start;
    assign busy        = (r_state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance.
// Expected streams follow PISO_PARITY_EN when it is defined.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = 9;
    localparam logic [31:0] EXP_5A   = 32'h0B4;
    localparam logic [31:0] EXP_A53C = 32'h29478;
    localparam logic [31:0] FS_B2B   = 32'h201;
    localparam logic [31:0] RDY_B2B  = 32'h20100;
    localparam logic [31:0] EXP_81   = 32'h102;
    localparam logic [31:0] EXP_L01  = 32'h101;
    localparam logic [31:0] EXP_07   = 32'h00F;
    localparam logic [31:0] EXP_03   = 32'h006;
`else
    localparam int FRAME = 8;
    localparam logic [31:0] EXP_5A   = 32'h05A;
    localparam logic [31:0] EXP_A53C = 32'hA53C;
    localparam logic [31:0] FS_B2B   = 32'h101;
    localparam logic [31:0] RDY_B2B  = 32'h8080;
    localparam logic [31:0] EXP_81   = 32'h081;
    localparam logic [31:0] EXP_L01  = 32'h080;
    localparam logic [31:0] EXP_07   = 32'h007;
    localparam logic [31:0] EXP_03   = 32'h003;
`endif
    localparam logic [31:0] RDY_LAST = 32'h1 << (FRAME - 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] dataM = '0;
    logic             validM = 1'b0;
    logic             readyM, doutM, dvM, fsM, busyM;
    logic [WIDTH-1:0] dataL = '0;
    logic             validL = 1'b0;
    logic             readyL, doutL, dvL, fsL, busyL;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] bits, validCnt, fsMask, readyMask;
    logic [31:0] bitsA, bitsB, vA, vB, fA, fB, rA, rB;
    logic        bit3;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .data_in(dataM), .load_valid(validM),
        .load_ready(readyM), .dout(doutM), .dout_valid(dvM),
        .frame_start(fsM), .busy(busyM)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .data_in(dataL), .load_valid(validL),
        .load_ready(readyL), .dout(doutL), .dout_valid(dvL),
        .frame_start(fsL), .busy(busyL)
    );

    // Free-running 10-time-unit clock; the bench acts on falling edges.
    always #5 clk = ~clk;

    // Counts every comparison and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents one word for a single accepting cycle; returns on the first-bit cycle.
    task automatic applyStimulus(input bit useLsb, input logic [WIDTH-1:0] word);
        if (useLsb) begin
            checkOutput("lsbReadyAtAccept", {31'b0, readyL}, 32'h1);
            dataL  = word;
            validL = 1'b1;
        end else begin
            checkOutput("msbReadyAtAccept", {31'b0, readyM}, 32'h1);
            dataM  = word;
            validM = 1'b1;
        end
        @(negedge clk);
        validL = 1'b0;
        validM = 1'b0;
    endtask

    // Samples n cycles; bits collects dout oldest-first, masks index by cycle.
    task automatic captureFrame(input bit useLsb, input int n, input int dropAt,
                                output logic [31:0] b, output logic [31:0] vc,
                                output logic [31:0] fm, output logic [31:0] rm);
        b  = '0;
        vc = '0;
        fm = '0;
        rm = '0;
        for (int i = 0; i < n; i++) begin
            if (i == dropAt) validM = 1'b0;
            b = {b[30:0], (useLsb ? doutL : doutM)};
            if (useLsb ? dvL : dvM)       vc = vc + 1;
            if (useLsb ? fsL : fsM)       fm[i] = 1'b1;
            if (useLsb ? readyL : readyM) rm[i] = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state, with valid offered to prove it is ignored while held.
        #1 reset = 1'b0;
        validM = 1'b1;
        @(negedge clk);
        checkOutput("rstDout",  {31'b0, doutM}, 32'h1);
        checkOutput("rstValid", {31'b0, dvM},   32'h0);
        checkOutput("rstFs",    {31'b0, fsM},   32'h0);
        checkOutput("rstBusy",  {31'b0, busyM}, 32'h0);
        checkOutput("rstReady", {31'b0, readyM}, 32'h0);
        validM = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single word 0x5A, MSB first.
        applyStimulus(1'b0, 8'h5A);
        captureFrame(1'b0, FRAME, -1, bits, validCnt, fsMask, readyMask);
        checkOutput("t1Bits",    bits, EXP_5A);
        checkOutput("t1Valid",   validCnt, FRAME);
        checkOutput("t1FrameSt", fsMask, 32'h1);
        checkOutput("t1Ready",   readyMask, RDY_LAST);
        checkOutput("t1IdleDout",  {31'b0, doutM}, 32'h1);
        checkOutput("t1IdleValid", {31'b0, dvM},   32'h0);
        checkOutput("t1IdleBusy",  {31'b0, busyM}, 32'h0);

        // Back-to-back 0xA5 then 0x3C with valid held for the second word.
        dataM  = 8'hA5;
        validM = 1'b1;
        @(negedge clk);
        dataM = 8'h3C;
        captureFrame(1'b0, 2 * FRAME, FRAME, bits, validCnt, fsMask, readyMask);
        checkOutput("t2Bits",    bits, EXP_A53C);
        checkOutput("t2Valid",   validCnt, 2 * FRAME);
        checkOutput("t2FrameSt", fsMask, FS_B2B);
        checkOutput("t2Ready",   readyMask, RDY_B2B);
        checkOutput("t2IdleValid", {31'b0, dvM}, 32'h0);

        // Valid pulsed on bit 3 must be ignored.
        applyStimulus(1'b0, 8'h81);
        captureFrame(1'b0, 2, -1, bitsA, vA, fA, rA);
        checkOutput("t3ReadyMid", {31'b0, readyM}, 32'h0);
        bit3   = doutM;
        dataM  = 8'h42;
        validM = 1'b1;
        @(negedge clk);
        validM = 1'b0;
        captureFrame(1'b0, FRAME - 3, -1, bitsB, vB, fB, rB);
        checkOutput("t3Bits", (bitsA << (FRAME - 2)) | ({31'b0, bit3} << (FRAME - 3)) | bitsB, EXP_81);
        checkOutput("t3NoAcceptBusy", {31'b0, busyM}, 32'h0);
        captureFrame(1'b0, 2, -1, bits, validCnt, fsMask, readyMask);
        checkOutput("t3NoAcceptValid", validCnt, 32'h0);

        // Asynchronous reset three bits into 0xFF.
        applyStimulus(1'b0, 8'hFF);
        captureFrame(1'b0, 3, -1, bits, validCnt, fsMask, readyMask);
        checkOutput("t4FirstBits", bits, 32'h7);
        #2 reset = 1'b0;
        #1;
        checkOutput("t4AsyncDout",  {31'b0, doutM},  32'h1);
        checkOutput("t4AsyncValid", {31'b0, dvM},    32'h0);
        checkOutput("t4AsyncBusy",  {31'b0, busyM},  32'h0);
        checkOutput("t4AsyncReady", {31'b0, readyM}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t4ReadyAfter", {31'b0, readyM}, 32'h1);
        captureFrame(1'b0, 4, -1, bits, validCnt, fsMask, readyMask);
        checkOutput("t4NoResidual", validCnt, 32'h0);
        checkOutput("t4IdleBits",   bits, 32'hF);

        // LSB-first instance, word 0x01.
        applyStimulus(1'b1, 8'h01);
        captureFrame(1'b1, FRAME, -1, bits, validCnt, fsMask, readyMask);
        checkOutput("t5Bits",    bits, EXP_L01);
        checkOutput("t5Valid",   validCnt, FRAME);
        checkOutput("t5FrameSt", fsMask, 32'h1);

        // Parity-sensitive words 0x07 and 0x03.
        applyStimulus(1'b0, 8'h07);
        captureFrame(1'b0, FRAME, -1, bits, validCnt, fsMask, readyMask);
        checkOutput("t6Bits07",  bits, EXP_07);
        checkOutput("t6Valid07", validCnt, FRAME);
        checkOutput("t6Ready07", readyMask, RDY_LAST);
        applyStimulus(1'b0, 8'h03);
        captureFrame(1'b0, FRAME, -1, bits, validCnt, fsMask, readyMask);
        checkOutput("t6Bits03",  bits, EXP_03);
        checkOutput("t6Ready03", readyMask, RDY_LAST);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
